// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU and load result channels into one register-file write port.
// Loads are byte/half extracted and checked for alignment before the registered write.
module wb_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_rd_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [4:0]  rd_o,
    output logic [31:0] wd_o,
    output logic        reg_write_o,
    output logic        ld_err_o
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_e;

    grant_e      last_grant_q, last_grant_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wd_q, wd_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic        conflict;
    logic        ld_wins;
    logic        alu_xfer;
    logic        ld_xfer;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic        ld_bad;

    // Arbitration; readies are forced low while reset is asserted.
    always_comb begin
        conflict = alu_valid_i & ld_valid_i;
        if (RR_EN) begin
            ld_wins = (last_grant_q == GRANT_ALU);
        end else begin
            ld_wins = 1'b1;
        end
        ld_ready_o  = rst_n & ld_valid_i  & (~alu_valid_i | ld_wins);
        alu_ready_o = rst_n & alu_valid_i & (~ld_valid_i  | ~ld_wins);
        alu_xfer    = alu_valid_i & alu_ready_o;
        ld_xfer     = ld_valid_i  & ld_ready_o;

        last_grant_d = last_grant_q;
        if (conflict) begin
            last_grant_d = ld_wins ? GRANT_LD : GRANT_ALU;
        end
    end

    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        ld_value = ld_rdata_i;
        ld_bad   = 1'b0;
        case (ld_funct3_i)
            3'b000: ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001: begin
                ld_value = {{16{ld_half[15]}}, ld_half};
                ld_bad   = ld_addr_lo_i[0];
            end
            3'b010: ld_bad = |ld_addr_lo_i;
            3'b100: ld_value = {24'd0, ld_byte};
            3'b101: begin
                ld_value = {16'd0, ld_half};
                ld_bad   = ld_addr_lo_i[0];
            end
            default: ld_bad = 1'b1;
        endcase
    end

    // rd/wd only move on an actual register write; everything else holds them.
    always_comb begin
        we_d  = 1'b0;
        err_d = 1'b0;
        rd_d  = rd_q;
        wd_d  = wd_q;
        if (ld_xfer) begin
            err_d = ld_bad;
            we_d  = ~ld_bad & (ld_rd_i != 5'd0);
            if (we_d) begin
                rd_d = ld_rd_i;
                wd_d = ld_value;
            end
        end else if (alu_xfer) begin
            we_d = (alu_rd_i != 5'd0);
            if (we_d) begin
                rd_d = alu_rd_i;
                wd_d = alu_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_ALU;
            rd_q         <= 5'd0;
            wd_q         <= 32'd0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_q         <= rd_d;
            wd_q         <= wd_d;
            we_q         <= we_d;
            err_q        <= err_d;
        end
    end

    assign rd_o        = rd_q;
    assign wd_o        = wd_q;
    assign reg_write_o = we_q;
    assign ld_err_o    = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: round-robin and fixed-priority instances driven in parallel,
// checked against a transaction-level model of grants, load extraction and writes.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_rdata;

    logic        alu_ready [2];
    logic        ld_ready  [2];
    logic [4:0]  rd        [2];
    logic [31:0] wd        [2];
    logic        reg_write [2];
    logic        ld_err    [2];

    int checks = 0;
    int errors = 0;

    // model state: index 0 = round-robin, 1 = fixed priority
    bit          rr_load_next;
    logic [4:0]  m_rd [2];
    logic [31:0] m_wd [2];

    always #5 clk = ~clk;

    wb_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready[0]),
        .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready[0]),
        .ld_rd_i(ld_rd), .ld_funct3_i(ld_funct3),
        .ld_addr_lo_i(ld_addr_lo), .ld_rdata_i(ld_rdata),
        .rd_o(rd[0]), .wd_o(wd[0]),
        .reg_write_o(reg_write[0]), .ld_err_o(ld_err[0])
    );

    wb_arbiter #(.RR_EN(1'b0)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready[1]),
        .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready[1]),
        .ld_rd_i(ld_rd), .ld_funct3_i(ld_funct3),
        .ld_addr_lo_i(ld_addr_lo), .ld_rdata_i(ld_rdata),
        .rd_o(rd[1]), .wd_o(wd[1]),
        .reg_write_o(reg_write[1]), .ld_err_o(ld_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] alo,
                                     input logic [31:0] w, output logic [31:0] v,
                                     output bit e);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * alo)) & 32'hFF;
        h = (w >> (16 * (alo / 2))) & 32'hFFFF;
        e = 1'b0;
        v = 32'd0;
        case (f3)
            3'd0: v = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1: begin v = (h >= 32768) ? h + 32'hFFFF0000 : h; e = (alo % 2) != 0; end
            3'd2: begin v = w; e = (alo != 0); end
            3'd4: v = b;
            3'd5: begin v = h; e = (alo % 2) != 0; end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        rr_load_next = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 5'd0;
            m_wd[k] = 32'd0;
        end
    endtask

    // One cycle: drive, check readies, clock, check the registered write port.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] rdat);
        logic [31:0] val;
        bit          bad;
        bit          okl [2];
        bit          oka [2];
        bit          we  [2];
        bit          er  [2];
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        ld_valid = lv;   ld_rd = lrd;   ld_funct3 = f3;
        ld_addr_lo = alo; ld_rdata = rdat;
        #1;
        ref_load(f3, alo, rdat, val, bad);
        for (int k = 0; k < 2; k++) begin
            okl[k] = lv && (!av || k == 1 || rr_load_next);
            oka[k] = av && !okl[k];
            chk($sformatf("ld_ready[%0d]", k), {31'd0, ld_ready[k]}, {31'd0, okl[k]});
            chk($sformatf("alu_ready[%0d]", k), {31'd0, alu_ready[k]}, {31'd0, oka[k]});
            we[k] = 1'b0;
            er[k] = 1'b0;
            if (okl[k]) begin
                er[k] = bad;
                we[k] = !bad && lrd != 0;
                if (we[k]) begin m_rd[k] = lrd; m_wd[k] = val; end
            end else if (oka[k]) begin
                we[k] = ard != 0;
                if (we[k]) begin m_rd[k] = ard; m_wd[k] = ad; end
            end
        end
        if (av && lv) rr_load_next = !okl[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reg_write[%0d]", k), {31'd0, reg_write[k]}, {31'd0, we[k]});
            chk($sformatf("ld_err[%0d]", k), {31'd0, ld_err[k]}, {31'd0, er[k]});
            chk($sformatf("rd[%0d]", k), {27'd0, rd[k]}, {27'd0, m_rd[k]});
            chk($sformatf("wd[%0d]", k), wd[k], m_wd[k]);
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1;
        ld_valid = 1'b1;  ld_rd = 5'd8;  ld_funct3 = 3'd2;
        ld_addr_lo = 2'd0; ld_rdata = 32'h2;
        model_reset();
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_reg_write", {31'd0, reg_write[k]}, 32'd0);
            chk("rst_ld_err", {31'd0, ld_err[k]}, 32'd0);
            chk("rst_rd", {27'd0, rd[k]}, 32'd0);
            chk("rst_wd", wd[k], 32'd0);
            chk("rst_alu_ready", {31'd0, alu_ready[k]}, 32'd0);
            chk("rst_ld_ready", {31'd0, ld_ready[k]}, 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;

        // conflict pattern: rr gives L,A,L,A; fixed gives L,L,L,L
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd1, 32'hA000_0000 + i, 1'b1, 5'd2, 3'd2, 2'd0, 32'hB000_0000 + i);
        idle();

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
        chk("alu_only_wd", wd[0], 32'hDEADBEEF);
        idle();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'd0, 2'd2, 32'h12F4_5678);
        chk("lb_wd", wd[0], 32'hFFFFFFF4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'd4, 2'd2, 32'h12F4_5678);
        chk("lbu_wd", wd[0], 32'h000000F4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 3'd5, 2'd2, 32'h12F4_5678);
        chk("lhu_wd", wd[0], 32'h000012F4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 3'd2, 2'd1, 32'h5555_AAAA);
        chk("lw_mis_err", {31'd0, ld_err[0]}, 32'd1);
        idle();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 3'd7, 2'd0, 32'h5555_AAAA);
        chk("f3_111_err", {31'd0, ld_err[0]}, 32'd1);
        idle();
        step(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
        chk("alu_rd0_we", {31'd0, reg_write[0]}, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 3'd2, 2'd0, 32'h7);
        idle();

        // reset mid-cycle just after a write lands
        step(1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        alu_valid = 1'b1;
        ld_valid = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_reg_write", {31'd0, reg_write[k]}, 32'd0);
            chk("midrst_rd", {27'd0, rd[k]}, 32'd0);
            chk("midrst_wd", wd[k], 32'd0);
            chk("midrst_alu_ready", {31'd0, alu_ready[k]}, 32'd0);
            chk("midrst_ld_ready", {31'd0, ld_ready[k]}, 32'd0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        idle();
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 3'd2, 2'd0, 32'h22);
        chk("post_rst_ld_first", {27'd0, rd[0]}, 32'd2);

        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration on conflict; 0 = fixed load-over-ALU priority.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 alu_valid_i  input  1  ALU result channel holds a valid writeback.
REQ-005 alu_ready_o  output  1  ALU writeback accepted this cycle when high with alu_valid_i.
REQ-006 alu_rd_i  input  5  ALU destination register.
REQ-007 alu_data_i  input  32  ALU result.
REQ-008 ld_valid_i  input  1  load channel holds valid memory read data.
REQ-009 ld_ready_o  output  1  load writeback accepted this cycle when high with ld_valid_i.
REQ-010 ld_rd_i  input  5  load destination register.
REQ-011 ld_funct3_i  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 ld_addr_lo_i  input  2  byte offset of load address.
REQ-013 ld_rdata_i  input  32  raw aligned memory word.
REQ-014 rd_o  output  5  register file destination address.
REQ-015 wd_o  output  32  register file write data.
REQ-016 reg_write_o  output  1  register file write enable.
REQ-017 ld_err_o  output  1  one-cycle pulse: accepted load was misaligned or had illegal funct3.

Function
REQ-018 Handshake: a transfer occurs on a channel in a cycle where its valid and ready are both high; ready is combinational from both valids and the arbitration pointer.
REQ-019 Only one valid: that channel's ready is 1; other ready is 0.
REQ-020 Both valid, RR_EN=0: load granted, alu_ready_o=0.
REQ-021 Both valid, RR_EN=1: grant the channel opposite last_grant; last_grant updates only on a conflict-resolved grant; last_grant resets to ALU (load wins first conflict).
REQ-022 Neither valid: both readies 0, last_grant unchanged.
REQ-023 Output stage is registered: rd_o/wd_o/reg_write_o reflect the transfer accepted in cycle N during cycle N+1 only; latency exactly 1, throughput 1 per cycle.
REQ-024 No transfer in cycle N: reg_write_o=0 in N+1; rd_o and wd_o hold previous values.
REQ-025 Load extract: byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes full word.
REQ-026 Misaligned: LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0 -> transfer accepted, reg_write_o=0, ld_err_o=1 in N+1.
REQ-027 Illegal funct3 (011, 110, 111) -> accepted, reg_write_o=0, ld_err_o=1 in N+1.
REQ-028 rd=0 on either channel -> accepted, reg_write_o=0, no error.
REQ-029 ld_err_o is 0 in every cycle not following an erroneous load transfer.

Reset
REQ-030 rst_n low asynchronously forces reg_write_o=0, ld_err_o=0, rd_o=0, wd_o=0, last_grant=ALU, regardless of clk.
REQ-031 While rst_n low, alu_ready_o=0 and ld_ready_o=0; any transfer in flight is dropped, no write issued after release.
REQ-032 First transfer is possible in the first rising edge with rst_n high.

Verification
REQ-033 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle reg_write_o=1, rd_o=5, wd_o=0xDEADBEEF.
REQ-034 LB: rdata=0x12F4_5678, addr_lo=2, rd=7 -> wd_o=0xFFFFFFF4; LBU same -> 0x000000F4; LHU addr_lo=2 -> 0x000012F4.
REQ-035 Conflict, RR_EN=1, both valid 4 cycles (ALU rd=1, load rd=2 LW) -> grants L,A,L,A; writes rd 2,1,2,1 on consecutive cycles; RR_EN=0 -> L,L,L,L.
REQ-036 LW addr_lo=1 rd=3 -> ld_ready_o=1, next cycle reg_write_o=0, ld_err_o=1 for one cycle; funct3=111 same response.
REQ-037 ALU rd=0 data=0x1 -> alu_ready_o=1, reg_write_o stays 0, ld_err_o=0.
REQ-038 Assert rst_n low mid-clock one cycle after a transfer -> reg_write_o drops to 0 immediately; after release, first conflict grants load.
